// File: rtl/pulso_boton.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM with a stability
// counter, single-cycle enable pulse and a wrap-around count of accepted presses.
//
// state        | meaning
// BAJO         | debounced level low, waiting for a high sample
// ESPERA_ALTO  | counting consecutive high samples before accepting a press
// ALTO         | debounced level high, press already pulsed
// ESPERA_BAJO  | counting consecutive low samples before accepting a release
module pulso_boton #(
    parameter int N_ESTABLE = 4,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          boton,
    output logic          enable,
    output logic          estable,
    output logic [CW-1:0] cuenta
);

    typedef enum logic [1:0] {
        BAJO        = 2'd0,
        ESPERA_ALTO = 2'd1,
        ALTO        = 2'd2,
        ESPERA_BAJO = 2'd3
    } estado_t;

    localparam logic [7:0] L_FIN = 8'(N_ESTABLE - 1);

    logic          r_s1;
    logic          r_s2;
    estado_t       r_estado;
    logic [7:0]    r_cnt;
    logic          r_enable;
    logic          r_estable;
    logic [CW-1:0] r_cuenta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_estado  <= BAJO;
            r_cnt     <= 8'd0;
            r_enable  <= 1'b0;
            r_estable <= 1'b0;
            r_cuenta  <= '0;
        end else begin
            r_s1     <= boton;
            r_s2     <= r_s1;
            r_enable <= 1'b0;
            case (r_estado)
                BAJO: begin
                    if (r_s2) begin
                        r_estado <= ESPERA_ALTO;
                        r_cnt    <= 8'd1;
                    end
                end
                ESPERA_ALTO: begin
                    if (!r_s2) begin
                        r_estado <= BAJO;
                        r_cnt    <= 8'd0;
                    end else if (r_cnt == L_FIN) begin
                        r_estado  <= ALTO;
                        r_cnt     <= 8'd0;
                        r_estable <= 1'b1;
                        r_enable  <= 1'b1;
                        r_cuenta  <= r_cuenta + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ALTO: begin
                    if (!r_s2) begin
                        r_estado <= ESPERA_BAJO;
                        r_cnt    <= 8'd1;
                    end
                end
                ESPERA_BAJO: begin
                    // a high sample here is a bounce on release: back to ALTO, no pulse
                    if (r_s2) begin
                        r_estado <= ALTO;
                        r_cnt    <= 8'd0;
                    end else if (r_cnt == L_FIN) begin
                        r_estado  <= BAJO;
                        r_cnt     <= 8'd0;
                        r_estable <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_estado  <= BAJO;
                    r_cnt     <= 8'd0;
                    r_estable <= 1'b0;
                end
            endcase
        end
    end

    assign enable  = r_enable;
    assign estable = r_estable;
    assign cuenta  = r_cuenta;

endmodule

// File: tb/tb_pulso_boton.sv
// Self-checking bench for pulso_boton: vector table, corner-case sequences and
// random button activity against a run-length debounce reference model.
module tb_pulso_boton;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic          boton;
    logic          enable;
    logic          estable;
    logic [CW-1:0] cuenta;

    int n_pass = 0;
    int n_tot  = 0;

    pulso_boton #(.N_ESTABLE(N), .CW(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .boton   (boton),
        .enable  (enable),
        .estable (estable),
        .cuenta  (cuenta)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    // Reference: pipeline of raw samples, then accept a level change once the
    // last N samples seen by the debouncer all disagree with the current level.
    bit q_b[$];
    bit q_seen[$];
    bit m_est;
    bit m_en;
    int m_cnt;
    bit prev_en;

    function automatic void model_reset();
        q_b.delete();
        q_b.push_back(1'b0);
        q_b.push_back(1'b0);
        q_seen.delete();
        m_est   = 1'b0;
        m_en    = 1'b0;
        m_cnt   = 0;
        prev_en = 1'b0;
    endfunction

    function automatic void model_edge(input bit b);
        bit seen;
        bit all_opp;
        seen = q_b[0];
        void'(q_b.pop_front());
        q_b.push_back(b);
        q_seen.push_back(seen);
        if (q_seen.size() > N) void'(q_seen.pop_front());
        m_en    = 1'b0;
        all_opp = (q_seen.size() == N);
        foreach (q_seen[i]) if (q_seen[i] == m_est) all_opp = 1'b0;
        if (all_opp) begin
            m_est = ~m_est;
            if (m_est) begin
                m_en  = 1'b1;
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input bit b);
        boton = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        chk("enable", int'(enable), int'(m_en));
        chk("estable", int'(estable), int'(m_est));
        chk("cuenta", int'(cuenta), m_cnt);
        chk("no_back_to_back", int'(prev_en & enable), 0);
        prev_en = enable;
    endtask

    task automatic do_reset();
        boton = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit       b;
        bit       en;
        bit       est;
        int       cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit b, input bit en, input bit est, input int cnt);
        vec_t v;
        v.b = b; v.en = en; v.est = est; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    initial begin
        int pulse_at;
        int pulses;
        bit fft_q;
        bit found;

        // Clean press (edge 1 samples 1; pulse after edge 6), release (edge 10
        // samples 0; estable falls at edge 15), then a 2-cycle glitch.
        for (int i = 1; i <= 9; i++)  add(1'b1, i == 6, i >= 6, (i >= 6) ? 1 : 0);
        for (int i = 10; i <= 17; i++) add(1'b0, 1'b0, i < 15, 1);
        add(1'b1, 1'b0, 1'b0, 1);
        add(1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 6; i++)   add(1'b0, 1'b0, 1'b0, 1);

        boton = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_enable", int'(enable), 0);
        chk("reset_estable", int'(estable), 0);
        chk("reset_cuenta", int'(cuenta), 0);
        reset = 1'b0;
        model_reset();

        foreach (vecs[i]) begin
            step(vecs[i].b);
            chk("vec_enable", int'(enable), int'(vecs[i].en));
            chk("vec_estable", int'(estable), int'(vecs[i].est));
            chk("vec_cuenta", int'(cuenta), vecs[i].cnt);
        end

        // Bounce 1,0,1,0 then steady high from edge 5: single pulse at edge 10.
        do_reset();
        pulse_at = 0;
        pulses   = 0;
        for (int e = 1; e <= 20; e++) begin
            step((e == 1 || e == 3 || e >= 5) ? 1'b1 : 1'b0);
            if (enable) begin
                pulses++;
                pulse_at = e;
            end
        end
        chk("bounce_pulses", pulses, 1);
        chk("bounce_pulse_edge", pulse_at, 10);
        chk("bounce_cuenta", int'(cuenta), 1);

        // Reset while enable is high, with the button still held.
        do_reset();
        found = 1'b0;
        for (int e = 0; e < 20 && !found; e++) begin
            step(1'b1);
            if (enable) found = 1'b1;
        end
        chk("wait_enable", int'(found), 1);
        #1 reset = 1'b1;
        #0.5;
        chk("midrst_enable", int'(enable), 0);
        chk("midrst_estable", int'(estable), 0);
        chk("midrst_cuenta", int'(cuenta), 0);
        #0.5 reset = 1'b0;
        model_reset();
        pulse_at = 0;
        pulses   = 0;
        for (int e = 1; e <= 10; e++) begin
            step(1'b1);
            if (enable) begin
                pulses++;
                pulse_at = e;
            end
        end
        chk("midrst_pulses", pulses, 1);
        chk("midrst_pulse_edge", pulse_at, 6);
        chk("midrst_cuenta_after", int'(cuenta), 1);

        // 256 clean presses: counter wraps and a chained toggle returns home.
        do_reset();
        fft_q  = 1'b0;
        pulses = 0;
        for (int p = 1; p <= 256; p++) begin
            for (int c = 0; c < 7; c++) begin
                step(1'b1);
                if (enable) begin
                    pulses++;
                    fft_q = ~fft_q;
                end
            end
            if (p == 255) chk("wrap_cuenta_255", int'(cuenta), 255);
            for (int c = 0; c < 7; c++) begin
                step(1'b0);
                if (enable) begin
                    pulses++;
                    fft_q = ~fft_q;
                end
            end
        end
        chk("wrap_pulses", pulses, 256);
        chk("wrap_cuenta_0", int'(cuenta), 0);
        chk("wrap_fft", int'(fft_q), 0);

        // Random bouncing activity with variable hold lengths.
        do_reset();
        for (int r = 0; r < 600; r++) begin
            bit lvl;
            int hold;
            lvl  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 7);
            for (int c = 0; c < hold; c++) step(lvl);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/pulso_boton.md
Name: pulso_boton

Overview:
- Upstream stage of the lab's T flip-flop (FFT). It turns a raw, bouncing push-button level into a clean single-cycle enable pulse, one pulse per accepted press.
- Inside: a 2-FF synchronizer, a debounce FSM with a stability counter, a pulse generator and a wrap-around press counter.
- The `enable` output connects directly to FFT's enable input, so each accepted press toggles FFT's output exactly once.

Parameters:
- N_ESTABLE, 4, consecutive synchronized samples required to accept a level change; legal range 2..255.
- CW, 8, width of the `cuenta` press counter.

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- boton  input  1  raw asynchronous push-button level; may bounce.
- enable  output  1  registered one-cycle pulse per accepted press; feeds FFT enable.
- estable  output  1  registered debounced button level.
- cuenta  output  CW  registered count of accepted presses; wraps.

Behaviour:
- Interface: one clock (`clk`); `reset` is asynchronous and active-high. Every flop, including both synchronizer stages, clears while `reset`=1.
- Reset values:
  - outputs: `enable`=0, `estable`=0, `cuenta`=0;
  - internal: FSM in BAJO, stability counter=0, sync stages s1=s2=0.
- Synchronizer: s1<=boton, s2<=s1. The FSM sees only s2, so there are 2 edges of input latency.
- Stability counter: 8 bits, internal; cleared on every state change.
- FSM states and transitions:
  - BAJO: s2=1 -> ESPERA_ALTO, counter=1. Otherwise stay.
  - ESPERA_ALTO:
    - s2=0 -> BAJO, counter=0 (bounce rejected).
    - s2=1 and counter=N_ESTABLE-1 -> ALTO, enable<=1, cuenta<=cuenta+1.
    - otherwise counter+1.
  - ALTO: enable<=0 on the next edge. s2=0 -> ESPERA_BAJO, counter=1.
  - ESPERA_BAJO:
    - s2=1 -> ALTO, counter=0 (no new pulse).
    - s2=0 and counter=N_ESTABLE-1 -> BAJO.
    - otherwise counter+1.
- estable: 1 in ALTO and ESPERA_BAJO, 0 in BAJO and ESPERA_ALTO. It is registered together with the state.
- Press latency: let edge k be the first edge that samples boton=1, with boton held high from then on.
  - enable and estable rise on edge k+N_ESTABLE+1; enable falls on edge k+N_ESTABLE+2.
  - With N_ESTABLE=4: enable is high for exactly the one cycle after edge k+5.
- Release latency: the same timing applies to estable falling. Release never generates a pulse.
- Pulse rules:
  - enable is never high on 2 consecutive cycles.
  - Holding boton high indefinitely gives exactly 1 pulse.
- Glitch rejection: any high glitch that the FSM sees (via s2) as fewer than N_ESTABLE consecutive samples gives no pulse and no change to estable.
- cuenta: increments by 1 on exactly the edge where enable rises. Modulo 2^CW: 255 -> 0 for CW=8.
- Reset mid-operation:
  - An asserted reset aborts any wait state and kills an in-flight enable pulse immediately (asynchronous).
  - If boton is still high when reset releases, it is treated as a new press. A pulse follows after the full latency, counted from the first edge after release.
- Simultaneous events: a reset edge and a clock edge in the same timestep -> reset wins. Outputs stay at reset values.

Test Plan:
- Clean press, N_ESTABLE=4, clk period 4 -> boton 0->1 and held high. enable=1 for exactly one cycle, rising 5 edges after the first edge sampling 1. estable=1 from the same edge. cuenta=1. No further pulses while held.
- Bounce rejection -> boton pattern 1,0,1,0 with each level held 1 clock, then steady 1. Exactly one pulse, issued N_ESTABLE+1 edges after the start of the steady level. cuenta=1.
- Short glitch -> boton high for 2 clocks, then low. enable stays 0, estable stays 0, cuenta=0.
- Release and re-press -> press, release held for 6+ clocks, press again. Two pulses, cuenta=2. estable falls 5 edges after the first edge sampling 0 on release. No pulse on release.
- Counter wrap -> apply 256 clean presses. cuenta goes 255 -> 0 on the 256th pulse. Chained FFT output equals its initial value.
- Reset mid-operation -> assert reset on the cycle enable=1. enable, estable and cuenta go to 0 immediately. With boton still high after release, one new pulse appears 5 edges later and cuenta=1.
